// File: rtl/imgproc_pkg.sv
// Shared definitions for the image-processor slave and its message reader:
// register map, status-word fields, message header and reader state encoding.
package imgproc_pkg;

  // Slave register map
  localparam logic [2:0] IMG_ADDR_STATUS = 3'd0;
  localparam logic [2:0] IMG_ADDR_MSG    = 3'd1;
  localparam logic [2:0] IMG_ADDR_ID     = 3'd2;
  localparam logic [2:0] IMG_ADDR_COLOUR = 3'd3;

  // Status word fields
  localparam int STAT_FLUSH_BIT = 4;
  localparam int STAT_CNT_LSB   = 8;
  localparam int STAT_CNT_MSB   = 15;

  // Writing this to the status register empties the slave's message FIFO
  localparam logic [31:0] IMG_FLUSH_WORD = 32'h1 << STAT_FLUSH_BIT;

  // "RBB" message header, zero-extended
  localparam logic [31:0] IMG_HDR_WORD = 32'h0052_4242;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_STAT_RD,
    ST_STAT_CAP,
    ST_HDR_RD,
    ST_HDR_CAP,
    ST_GAP,
    ST_DAT_RD,
    ST_DAT_CAP,
    ST_PUBLISH,
    ST_GAP_RESYNC
  } rd_state_e;

endpackage

// File: rtl/imgproc_mm_rd_port.sv
// Single-transfer bus sequencer. A request becomes a one-cycle registered
// strobe; requests arriving while a strobe is on the bus are ignored, so every
// strobe is followed by at least one idle cycle (the slave edge-detects reads).
// Read data is handed back in the cycle after the strobe with rd_done high.
module imgproc_mm_rd_port
  import imgproc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [2:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic [31:0] rd_data,
  output logic        rd_done
);

  logic        rd_q, rd_d, wr_q, wr_d, cap_q, cap_d;
  logic [2:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        bus_idle;

  assign bus_idle = !(rd_q || wr_q);

  // Launch a strobe only from an idle bus cycle; reads win over writes
  always_comb begin
    rd_d    = bus_idle && req_rd;
    wr_d    = bus_idle && req_wr && !req_rd;
    addr_d  = (rd_d || wr_d) ? req_addr : 3'd0;
    wdata_d = wr_d ? req_wdata : 32'd0;
    cap_d   = rd_q;
  end

  // Bus-side registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cap_q   <= 1'b0;
      addr_q  <= 3'd0;
      wdata_q <= 32'd0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cap_q   <= cap_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign m_chipselect = rd_q || wr_q;
  assign m_read       = rd_q;
  assign m_write      = wr_q;
  assign m_address    = addr_q;
  assign m_writedata  = wdata_q;
  assign rd_data      = m_readdata;
  assign rd_done      = cap_q;

endmodule

// File: rtl/imgproc_msg_reader.sv
// Drains the image processor's area-message FIFO: polls the status word,
// reads header + red/yellow/blue, and publishes the three areas atomically
// with a one-cycle areas_valid strobe.
// Build option IMGPROC_MSG_FLUSH_EN: flush the slave FIFO after reset and on
// every header mismatch instead of discarding a single word.
module imgproc_msg_reader
  import imgproc_pkg::*;
#(
  parameter int          POLL_CYCLES = 1024,
  parameter int          MSG_WORDS   = 4,
  parameter logic [31:0] HDR_WORD    = IMG_HDR_WORD,
  parameter logic [2:0]  ADDR_STATUS = IMG_ADDR_STATUS,
  parameter logic [2:0]  ADDR_MSG    = IMG_ADDR_MSG
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic [31:0] area_red,
  output logic [31:0] area_yellow,
  output logic [31:0] area_blue,
  output logic        areas_valid,
  output logic [7:0]  sync_err_count,
  output logic        busy
);

  localparam int TW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam int KW = (MSG_WORDS > 2) ? $clog2(MSG_WORDS) : 1;
  localparam int NA = MSG_WORDS - 1;

  rd_state_e            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [KW-1:0]        k_q, k_d;
  logic [NA-1:0][31:0]  shadow_q, shadow_d;
  logic [NA-1:0][31:0]  area_q, area_d;
  logic                 valid_q, valid_d;
  logic [7:0]           err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 req_rd, req_wr;
  logic [2:0]           req_addr;
  logic [31:0]          rd_data;
  logic                 rd_done;
  logic [7:0]           stat_cnt;
`ifdef IMGPROC_MSG_FLUSH_EN
  logic                 flush_pend_q, flush_pend_d;
`endif

  assign stat_cnt = rd_data[STAT_CNT_MSB:STAT_CNT_LSB];

  // Next-state and datapath; bus requests are derived from the next state so
  // the registered strobe lines up with the *_RD / FLUSH state cycle
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    area_d   = area_q;
    valid_d  = 1'b0;
    err_d    = err_q;
`ifdef IMGPROC_MSG_FLUSH_EN
    flush_pend_d = flush_pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (timer_q != '0) timer_d = timer_q - 1'b1;
        else if (enable) begin
          state_d = ST_STAT_RD;
`ifdef IMGPROC_MSG_FLUSH_EN
          if (flush_pend_q) state_d = ST_FLUSH;
`endif
        end
      end
      ST_FLUSH: begin
`ifdef IMGPROC_MSG_FLUSH_EN
        flush_pend_d = 1'b0;
`endif
        state_d = ST_GAP_RESYNC;
      end
      ST_STAT_RD: state_d = ST_STAT_CAP;
      ST_STAT_CAP: if (rd_done) begin
        if (stat_cnt >= 8'(MSG_WORDS) && enable) state_d = ST_HDR_RD;
        else begin
          // Too few words: back off for a poll interval; disabled: park
          state_d = ST_IDLE;
          timer_d = (stat_cnt < 8'(MSG_WORDS)) ? TW'(POLL_CYCLES - 1) : '0;
        end
      end
      ST_HDR_RD: state_d = ST_HDR_CAP;
      ST_HDR_CAP: if (rd_done) begin
        if (rd_data == HDR_WORD) begin
          k_d     = '0;
          state_d = ST_GAP;
        end else begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
`ifdef IMGPROC_MSG_FLUSH_EN
          state_d = ST_FLUSH;
`else
          // Drop just this word; the next one is tried as a header
          state_d = ST_GAP_RESYNC;
`endif
        end
      end
      ST_GAP:    state_d = ST_DAT_RD;
      ST_DAT_RD: state_d = ST_DAT_CAP;
      ST_DAT_CAP: if (rd_done) begin
        shadow_d[k_q] = rd_data;
        if (k_q < KW'(MSG_WORDS - 2)) begin
          k_d     = k_q + 1'b1;
          state_d = ST_GAP;
        end else state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        area_d  = shadow_q;
        valid_d = 1'b1;
        state_d = ST_GAP_RESYNC;
      end
      ST_GAP_RESYNC: begin
        // Go straight back to the status read so queued messages drain
        timer_d = '0;
        state_d = enable ? ST_STAT_RD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d   = (state_d != ST_IDLE);
    req_rd   = (state_d == ST_STAT_RD) || (state_d == ST_HDR_RD) || (state_d == ST_DAT_RD);
    req_wr   = (state_d == ST_FLUSH);
    req_addr = ((state_d == ST_HDR_RD) || (state_d == ST_DAT_RD)) ? ADDR_MSG : ADDR_STATUS;
  end

  // Reader state and published outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      k_q      <= '0;
      shadow_q <= '0;
      area_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 8'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
      area_q   <= area_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

`ifdef IMGPROC_MSG_FLUSH_EN
  // A flush is owed after every reset, ahead of the first poll
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flush_pend_q <= 1'b1;
    else          flush_pend_q <= flush_pend_d;
  end
`endif

  imgproc_mm_rd_port u_port (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (IMG_FLUSH_WORD),
    .m_chipselect (m_chipselect),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .rd_data      (rd_data),
    .rd_done      (rd_done)
  );

  assign area_red       = area_q[0];
  assign area_yellow    = area_q[1];
  assign area_blue      = area_q[2];
  assign areas_valid    = valid_q;
  assign sync_err_count = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Directed bench for imgproc_msg_reader with a queue-backed slave model.
module tb_imgproc_msg_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        m_chipselect, m_read, m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = 32'hA5A5_A5A5;
  logic [31:0] area_red, area_yellow, area_blue;
  logic        areas_valid;
  logic [7:0]  sync_err_count;
  logic        busy;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] HDR = 32'h0052_4242;

  imgproc_msg_reader dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .area_red(area_red), .area_yellow(area_yellow), .area_blue(area_blue),
    .areas_valid(areas_valid), .sync_err_count(sync_err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave model: status reports queue depth; message reads pop; data valid
  // only in the cycle after the strobe
  logic [31:0] msgq[$];
  always @(posedge clk) begin
    if (m_chipselect && m_read) begin
      if (m_address == 3'd1) m_readdata <= (msgq.size() > 0) ? msgq.pop_front() : 32'd0;
      else                   m_readdata <= {16'd0, 8'(msgq.size()), 8'd0};
    end else m_readdata <= 32'hA5A5_A5A5;
    if (m_chipselect && m_write && m_address == 3'd0 && m_writedata[4]) msgq.delete();
  end

  // Bus/event monitor
  int cyc = 0, rd_total = 0, stat_rd = 0, msg_rd = 0, gap_viol = 0, vcount = 0;
  int last_stat = 0, prev_stat = 0;
  logic prev_cs = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    prev_cs <= m_chipselect;
    if (m_chipselect && prev_cs) gap_viol <= gap_viol + 1;
    if (m_chipselect && m_read) begin
      rd_total <= rd_total + 1;
      if (m_address == 3'd0) begin
        stat_rd   <= stat_rd + 1;
        prev_stat <= last_stat;
        last_stat <= cyc;
      end
      if (m_address == 3'd1) msg_rd <= msg_rd + 1;
    end
    if (areas_valid) vcount <= vcount + 1;
  end

  task automatic push_msg(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    msgq.push_back(HDR); msgq.push_back(a); msgq.push_back(b); msgq.push_back(c);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (areas_valid) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (area_red !== 32'd0 || area_yellow !== 32'd0 || area_blue !== 32'd0) begin
      bad++; $display("FAIL reset_areas got %h/%h/%h want 0", area_red, area_yellow, area_blue); end
    total++; if (areas_valid !== 1'b0 || sync_err_count !== 8'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_flags got v=%b e=%0d b=%b want 0", areas_valid, sync_err_count, busy); end
    total++; if (m_chipselect !== 1'b0 || m_read !== 1'b0 || m_write !== 1'b0 || m_address !== 3'd0 || m_writedata !== 32'd0) begin
      bad++; $display("FAIL reset_bus got cs=%b rd=%b wr=%b a=%0d wd=%h want idle", m_chipselect, m_read, m_write, m_address, m_writedata); end
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
`ifdef IMGPROC_MSG_FLUSH_EN
    total++; if (!(m_chipselect && m_write && !m_read && m_address == 3'd0 && m_writedata == 32'h10)) begin
      bad++; $display("FAIL first_flush got cs=%b wr=%b rd=%b a=%0d wd=%h want write 0 0x10", m_chipselect, m_write, m_read, m_address, m_writedata); end
`else
    total++; if (!(m_chipselect && m_read && m_address == 3'd0)) begin
      bad++; $display("FAIL first_poll got cs=%b rd=%b a=%0d want read addr 0", m_chipselect, m_read, m_address); end
`endif
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single_msg;
    int rb, mb, gb, vb; bit ok;
    rb = rd_total; mb = msg_rd; gb = gap_viol; vb = vcount;
    push_msg(32'd100, 32'd200, 32'd300);
    wait_valid(3000, ok);
    #1;
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got no areas_valid want pulse"); end
    total++; if (area_red !== 32'd100 || area_yellow !== 32'd200 || area_blue !== 32'd300) begin
      bad++; $display("FAIL single_areas got %0d/%0d/%0d want 100/200/300", area_red, area_yellow, area_blue); end
    total++; if (rd_total - rb != 5) begin bad++; $display("FAIL single_reads got %0d want 5", rd_total - rb); end
    total++; if (msg_rd - mb != 4) begin bad++; $display("FAIL single_msg_reads got %0d want 4", msg_rd - mb); end
    repeat (10) @(negedge clk); #1;
    total++; if (vcount - vb != 1) begin bad++; $display("FAIL single_pulses got %0d want 1", vcount - vb); end
    total++; if (gap_viol != gb) begin bad++; $display("FAIL single_gap got %0d back-to-back strobes want 0", gap_viol - gb); end
    total++; if (sync_err_count !== 8'd0) begin bad++; $display("FAIL single_err got %0d want 0", sync_err_count); end
  endtask

  task automatic test_short_count;
    int sb, mb; bit ok;
    msgq.push_back(32'd1); msgq.push_back(32'd2);
    sb = stat_rd; mb = msg_rd; ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (stat_rd - sb >= 2) begin ok = 1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL short_timeout got %0d polls want 2", stat_rd - sb); end
    total++; if (last_stat - prev_stat != 1026) begin
      bad++; $display("FAIL short_interval got %0d want 1026", last_stat - prev_stat); end
    total++; if (msg_rd != mb) begin bad++; $display("FAIL short_msg_reads got %0d want 0", msg_rd - mb); end
    msgq.delete();
  endtask

  task automatic test_resync;
    bit ok;
    msgq.push_back(32'hDEAD_BEEF);
    push_msg(32'd7, 32'd8, 32'd9);
`ifdef IMGPROC_MSG_FLUSH_EN
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_chipselect && m_write) begin ok = 1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL resync_flush got no flush write want one"); end
    @(negedge clk);
    push_msg(32'd7, 32'd8, 32'd9);
`endif
    wait_valid(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL resync_timeout got no areas_valid want pulse"); end
    total++; if (sync_err_count !== 8'd1) begin bad++; $display("FAIL resync_err got %0d want 1", sync_err_count); end
    total++; if (area_red !== 32'd7 || area_yellow !== 32'd8 || area_blue !== 32'd9) begin
      bad++; $display("FAIL resync_areas got %0d/%0d/%0d want 7/8/9", area_red, area_yellow, area_blue); end
  endtask

  task automatic test_back_to_back;
    bit ok; int n, idle_cyc;
    push_msg(32'd11, 32'd12, 32'd13);
    push_msg(32'd21, 32'd22, 32'd23);
    wait_valid(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout1 got no areas_valid want pulse"); end
    total++; if (area_red !== 32'd11 || area_yellow !== 32'd12 || area_blue !== 32'd13) begin
      bad++; $display("FAIL b2b_first got %0d/%0d/%0d want 11/12/13", area_red, area_yellow, area_blue); end
    n = 0; idle_cyc = 0; ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); n++;
      if (!busy) idle_cyc++;
      if (areas_valid) begin ok = 1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout2 got no second pulse want pulse"); end
    total++; if (n != 15) begin bad++; $display("FAIL b2b_spacing got %0d want 15", n); end
    total++; if (idle_cyc != 0) begin bad++; $display("FAIL b2b_idle got %0d idle cycles want 0", idle_cyc); end
    total++; if (area_red !== 32'd21 || area_yellow !== 32'd22 || area_blue !== 32'd23) begin
      bad++; $display("FAIL b2b_second got %0d/%0d/%0d want 21/22/23", area_red, area_yellow, area_blue); end
  endtask

  task automatic test_enable_off;
    bit ok; int sb;
    push_msg(32'd41, 32'd42, 32'd43);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_chipselect && m_read && m_address == 3'd1) begin ok = 1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL en_timeout got no header read want one"); end
    enable = 1'b0;
    wait_valid(100, ok);
    total++; if (!ok || area_red !== 32'd41 || area_yellow !== 32'd42 || area_blue !== 32'd43) begin
      bad++; $display("FAIL en_publish got ok=%0d %0d/%0d/%0d want 41/42/43", ok, area_red, area_yellow, area_blue); end
    #1; sb = stat_rd;
    repeat (40) @(negedge clk); #1;
    total++; if (stat_rd != sb || busy !== 1'b0) begin
      bad++; $display("FAIL en_park got polls=%0d busy=%b want 0/0", stat_rd - sb, busy); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid;
    int n, vb;
    push_msg(32'd31, 32'd32, 32'd33);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_chipselect && m_read && m_address == 3'd1) n++;
      if (n == 3) break;
    end
    total++; if (n != 3) begin bad++; $display("FAIL rmid_timeout got %0d msg reads want 3", n); end
    reset_n = 1'b0;
    #1;
    total++; if (area_red !== 32'd0 || area_yellow !== 32'd0 || area_blue !== 32'd0) begin
      bad++; $display("FAIL rmid_areas got %0d/%0d/%0d want 0", area_red, area_yellow, area_blue); end
    total++; if (areas_valid !== 1'b0 || sync_err_count !== 8'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_flags got v=%b e=%0d b=%b want 0", areas_valid, sync_err_count, busy); end
    total++; if (m_chipselect !== 1'b0 || m_read !== 1'b0) begin
      bad++; $display("FAIL rmid_bus got cs=%b rd=%b want 0", m_chipselect, m_read); end
    vb = vcount;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
`ifdef IMGPROC_MSG_FLUSH_EN
    total++; if (!(m_chipselect && m_write && m_address == 3'd0)) begin
      bad++; $display("FAIL rmid_first got cs=%b wr=%b a=%0d want flush write", m_chipselect, m_write, m_address); end
`else
    total++; if (!(m_chipselect && m_read && m_address == 3'd0)) begin
      bad++; $display("FAIL rmid_first got cs=%b rd=%b a=%0d want status read", m_chipselect, m_read, m_address); end
`endif
    repeat (30) @(negedge clk); #1;
    total++; if (vcount != vb || area_red !== 32'd0) begin
      bad++; $display("FAIL rmid_nopub got pulses=%0d red=%0d want 0/0", vcount - vb, area_red); end
  endtask

  initial begin
    test_reset;
    test_single_msg;
    test_short_count;
    test_resync;
    test_back_to_back;
    test_enable_off;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
